spi_write_ctrl: RTL
===================

SPI_WRITE_CTRL -- requirements
Module: spi_write_ctrl

Interface
REQ-001 Parameter: N, default 8, transfer width in bits (N >= 2).
REQ-002 Parameter: CLK_DIV, default 4, clk cycles per SCLK half-period (>= 1).
REQ-003 Parameter: CS_SETUP, default 2, clk cycles with cs_n low before the first SCLK rise (>= 1).
REQ-004 Parameter: CS_HOLD, default 2, clk cycles with cs_n low after the last SCLK fall (>= 1).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request a write of din; sampled only in IDLE.
REQ-008 din  input  N  write word; captured on the clk edge that accepts start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse marking transfer completion.
REQ-011 cs_n  output  1  SPI chip select, active low.
REQ-012 sclk  output  1  SPI clock, mode 0 (idle low, data sampled by slave on rising edge).
REQ-013 mosi  output  1  SPI serial data out.

Function
REQ-014 All outputs SHALL be driven directly from registers (no combinational paths from inputs).
REQ-015 FSM states: IDLE, SETUP, SHIFT, HOLD, DONE; encoding is free.
REQ-016 IDLE: cs_n=1, sclk=0, mosi=0, busy=0, done=0; start=1 at an edge loads din into an internal N-bit shift register and enters SETUP.
REQ-017 SETUP: lasts CS_SETUP cycles; cs_n=0, sclk=0, mosi=first transmit bit; then enters SHIFT.
REQ-018 SHIFT: N bit periods of 2*CLK_DIV cycles each; sclk=0 for the first CLK_DIV cycles, sclk=1 for the next CLK_DIV cycles.
REQ-019 The shift register SHALL advance by one bit, and mosi SHALL update, only on the edge where sclk goes 1->0, so mosi is stable throughout each sclk-high phase.
REQ-020 After the N-th sclk fall, the FSM enters HOLD; HOLD lasts CS_HOLD cycles with cs_n=0, sclk=0, mosi=last bit.
REQ-021 DONE: exactly one cycle with cs_n=1, sclk=0, done=1, busy=1; then returns to IDLE.
REQ-022 Latency: with start accepted at edge E0, done SHALL be high in cycle E0+CS_SETUP+2*CLK_DIV*N+CS_HOLD+1; defaults give cycle 69.
REQ-023 Exactly N sclk rising edges per transfer; no sclk pulses outside SHIFT.
REQ-024 start while busy=1, including the DONE cycle, SHALL be ignored, and din changes SHALL NOT affect the transfer in progress.
REQ-025 start in the first IDLE cycle after DONE SHALL be accepted; this guarantees cs_n high for at least one cycle between transfers.
REQ-026 Internal counters SHALL be sized to hold N, CLK_DIV, CS_SETUP and CS_HOLD without overflow, and SHALL wrap only on state change.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force IDLE with cs_n=1, sclk=0, mosi=0, busy=0, done=0, and clear all counters and the shift register.
REQ-028 reset asserted mid-transfer SHALL abort the transfer with no done pulse; the first start after reset deassertion SHALL begin a fresh transfer.

Configuration
REQ-029 Macro SPI_WR_LSB_FIRST_EN: when undefined, bits are sent MSB first (din[N-1] first); when defined, bits are sent LSB first (din[0] first); timing is identical in both builds.

Verification
REQ-030 Defaults, din=8'hC4, start pulse -> cs_n falls 1 cycle after the start edge; mosi at the 8 sclk rises = 1,1,0,0,0,1,0,0; done high in cycle 69; busy=1 for cycles 1..69.
REQ-031 Same stimulus with SPI_WR_LSB_FIRST_EN defined -> mosi at the sclk rises = 0,0,1,0,0,0,1,1; all timing identical to REQ-030.
REQ-032 start=1 and din=8'hFF held throughout a transfer of 8'hC4 -> bits remain per REQ-030; the next transfer begins in cycle 70 (IDLE), with cs_n high during cycle 69.
REQ-033 reset asserted between the 3rd and 4th sclk rise -> cs_n=1, sclk=0, mosi=0, busy=0 asynchronously; no done pulse; a following start with 8'h5A transfers 0,1,0,1,1,0,1,0.
REQ-034 N=16, CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, din=16'h8001 -> 16 sclk rises, mosi=1 first and last, 0 otherwise; done in cycle 35.

Source files
------------

// File: rtl/spi_write_ctrl.sv
// rtl/spi_write_ctrl.sv - SPI mode-0 write-only master; SPI_WR_LSB_FIRST_EN selects LSB-first shifting.
// All outputs are registered copies of values derived from the next state.
module spi_write_ctrl #(
  parameter int N        = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] din,
  output logic         busy,
  output logic         done,
  output logic         cs_n,
  output logic         sclk,
  output logic         mosi
);

  localparam int M1   = (2 * CLK_DIV > CS_SETUP) ? 2 * CLK_DIV : CS_SETUP;
  localparam int CMAX = (M1 > CS_HOLD) ? M1 : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(N + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] PER_LAST   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  sr_q, sr_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          active_d;
  logic          tx_bit_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = din;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // End of a bit period is the sclk fall: advance the shifter here only.
        if (cnt_q == PER_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
`ifdef SPI_WR_LSB_FIRST_EN
            sr_d  = {1'b0, sr_q[N-1:1]};
`else
            sr_d  = {sr_q[N-2:0], 1'b0};
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
`ifdef SPI_WR_LSB_FIRST_EN
    tx_bit_d = sr_d[0];
`else
    tx_bit_d = sr_d[N-1];
`endif
    active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
    cs_n_d   = ~active_d;
    sclk_d   = (state_d == ST_SHIFT) && (cnt_d >= HALF);
    mosi_d   = active_d & tx_bit_d;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
